// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer: state encoding and sizing.
package scan_pkg;
  localparam int unsigned PRESCALE_DEFAULT = 4;
  localparam int unsigned CODE_W           = 2;
  localparam int unsigned SWEEP_STEPS      = 4;
  localparam int unsigned SWEEP_CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan sequencer and whatever drives it.
interface scan_sequencer_if;
  logic                          en;
  logic                          start;
  logic                          dir;
  logic                          load;
  logic [scan_pkg::CODE_W-1:0]   load_val;
  logic                          a;
  logic                          b;
  logic                          step;
  logic                          wrap;
  logic                          busy;
  logic                          done;

  modport master (output en, start, dir, load, load_val,
                  input  a, b, step, wrap, busy, done);
  modport slave  (input  en, start, dir, load, load_val,
                  output a, b, step, wrap, busy, done);
endinterface

// File: rtl/scan_prescaler.sv
// Cycle divider: counts 0..PRESCALE-1 while run is high; tc marks the last count.
module scan_prescaler #(
  parameter int unsigned PRESCALE = scan_pkg::PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tc
);
  localparam int unsigned      CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/scan_sequencer.sv
// Two-bit scan code generator for a 2-to-4 decoder: free-running or single four-step sweep.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  scan_sequencer_if.slave   bus
);
  state_e                 state, state_nxt;
  logic [CODE_W-1:0]      code, code_nxt;
  logic [SWEEP_CNT_W-1:0] sweep_cnt, sweep_cnt_nxt;
  logic                   step_q, wrap_q, busy_q, done_q;
  logic                   step_nxt, wrap_nxt, busy_nxt, done_nxt;
  logic                   tc, run_c, clr_c;
  logic [CODE_W-1:0]      stepped_c;
  logic                   wraps_c;

  // Prescaler restarts whenever stepping is not active, on a RUN load, and on leaving RUN.
  assign run_c = (state == ST_RUN) || (state == ST_SWEEP);
  assign clr_c = !run_c || ((state == ST_RUN) && (bus.load || !bus.en));

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (clr_c),
    .run (run_c),
    .tc  (tc)
  );

  assign stepped_c = bus.dir ? (code - CODE_W'(1)) : (code + CODE_W'(1));
  assign wraps_c   = bus.dir ? (code == CODE_W'(0)) : (code == CODE_W'(3));

  always_comb begin
    state_nxt     = state;
    code_nxt      = code;
    sweep_cnt_nxt = sweep_cnt;
    step_nxt      = 1'b0;
    wrap_nxt      = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      ST_IDLE: begin
        sweep_cnt_nxt = '0;
        if (bus.load) code_nxt = bus.load_val;
        if (bus.en) begin
          state_nxt = ST_RUN;
        end else if (bus.start) begin
          state_nxt = ST_SWEEP;
        end
      end
      ST_RUN: begin
        if (!bus.en) state_nxt = ST_IDLE;
        // A load wins over a coincident step.
        if (bus.load) begin
          code_nxt = bus.load_val;
        end else if (bus.en && tc) begin
          code_nxt = stepped_c;
          step_nxt = 1'b1;
          wrap_nxt = wraps_c;
        end
      end
      ST_SWEEP: begin
        // One settle cycle after the last step before DONE.
        if (sweep_cnt == SWEEP_CNT_W'(SWEEP_STEPS)) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else if (tc) begin
          code_nxt      = stepped_c;
          step_nxt      = 1'b1;
          wrap_nxt      = wraps_c;
          sweep_cnt_nxt = sweep_cnt + SWEEP_CNT_W'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_SWEEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      code      <= '0;
      sweep_cnt <= '0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      code      <= code_nxt;
      sweep_cnt <= sweep_cnt_nxt;
      step_q    <= step_nxt;
      wrap_q    <= wrap_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bus.a    = code[1];
  assign bus.b    = code[0];
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, meaning clock cycles per code step; legal range 1..256.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port en  input  1  level; continuous stepping while high.
REQ-005 SHALL have port start  input  1  pulse; request one single sweep of four steps.
REQ-006 SHALL have port dir  input  1  0 = count up, 1 = count down; sampled at each step.
REQ-007 SHALL have port load  input  1  pulse; load code from load_val.
REQ-008 SHALL have port load_val  input  2  code to load.
REQ-009 SHALL have port a  output  1  code bit 1 (MSB), registered; drives the downstream 2-to-4 decoder input a.
REQ-010 SHALL have port b  output  1  code bit 0 (LSB), registered; drives decoder input b.
REQ-011 SHALL have port step  output  1  one-cycle pulse, high in the cycle the new code first appears on a/b.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse coincident with step when code goes 3->0 (up) or 0->3 (down).
REQ-013 SHALL have port busy  output  1  high while in RUN or SWEEP.
REQ-014 SHALL have port done  output  1  one-cycle pulse on completion of a single sweep.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, SWEEP, DONE.
REQ-016 IDLE: en=1 -> RUN; else start=1 -> SWEEP; else stay; en wins over start when both high.
REQ-017 RUN: en=0 -> IDLE with prescaler cleared; code holds its last value.
REQ-018 SWEEP: after the 4th step -> DONE; en, start and load ignored in SWEEP.
REQ-019 DONE: done=1 for exactly that cycle, then unconditionally -> IDLE; start in DONE ignored.
REQ-020 Prescaler SHALL count 0..PRESCALE-1 in RUN/SWEEP and clear on entry to RUN/SWEEP; a step occurs in the cycle the count equals PRESCALE-1, so the first step appears on a/b PRESCALE cycles after the state entry edge.
REQ-021 PRESCALE=1 SHALL step every cycle in RUN/SWEEP.
REQ-022 Step SHALL update code = code+1 mod 4 (dir=0) or code-1 mod 4 (dir=1); 2-bit wrap-around, no saturation.
REQ-023 Single sweep SHALL end with code equal to its start value if dir is constant during the sweep.
REQ-024 load SHALL be honored in IDLE and RUN: code <= load_val next edge, prescaler cleared, no step/wrap pulse.
REQ-025 load with en=1 in IDLE SHALL both load and enter RUN in the same edge.
REQ-026 load coinciding with a RUN step SHALL take priority; step is suppressed.
REQ-027 busy SHALL be registered, combinationally consistent with state (high in RUN, SWEEP; low in IDLE, DONE).

Reset
REQ-028 rst high SHALL immediately force state IDLE, code 0, prescaler 0, a=b=step=wrap=busy=done=0.
REQ-029 rst asserted mid-RUN or mid-SWEEP SHALL abort with no done pulse; after release, block waits in IDLE.
REQ-030 First edge after rst release SHALL evaluate IDLE transitions normally.

Structure
REQ-031 Shared package scan_pkg SHALL hold the state encoding typedef (2 bits) and the default PRESCALE constant.
REQ-032 Prescaler SHALL be a sub-module scan_prescaler (inputs clk, rst, clr, run; output tc pulse).
REQ-033 Top level SHALL contain only FSM, code register and output pulse registers.

Verification (PRESCALE=4 unless stated)
REQ-034 Reset, en=1, dir=0 for 16 cycles -> a/b sequence 00,01,10,11,00 each held 4 cycles; wrap with 11->00 step only.
REQ-035 load_val=2 load in IDLE, then start, dir=1 -> codes 1,0,3,2 at 4-cycle spacing, wrap on 0->3, done one cycle after 4th step, busy low next cycle.
REQ-036 en and start high same cycle in IDLE -> RUN (busy stays high past 16 cycles, no done).
REQ-037 rst pulsed 6 cycles into SWEEP -> a=b=0, busy=0 immediately, no done pulse ever.
REQ-038 load_val=3 in RUN coinciding with step -> code 3 next edge, no step pulse, next step 4 cycles later to 0 with wrap.
REQ-039 PRESCALE=1, en=1, dir=1 -> code 3,2,1,0,3 on consecutive cycles, step high every cycle.
